// File: rtl/bp_be_pkg.sv
// Shared backend types for the late writeback path: source identifiers and the
// writeback packet layout presented to the register files and scoreboards.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_late_src_mem  = 2'd0,
    e_late_src_idiv = 2'd1,
    e_late_src_fdiv = 2'd2
  } bp_be_late_src_e;

  localparam int dword_width_gp    = 64;
  localparam int reg_addr_width_gp = 5;
  localparam int fflags_width_gp   = 5;

  typedef struct packed {
    logic                         ird_w_v;
    logic                         frd_w_v;
    logic [reg_addr_width_gp-1:0] rd_addr;
    logic [dword_width_gp-1:0]    data;
    logic [fflags_width_gp-1:0]   fflags;
  } bp_be_wb_pkt_s;

endpackage

// File: rtl/bp_be_late_wb_fifo.sv
// Per-source circular buffer for late writeback packets. Ready depends only on
// the registered count, so a full buffer refuses input even while it drains.
module bp_be_late_wb_fifo
  import bp_be_pkg::*;
  #(parameter int els_p   = 2,
    parameter int width_p = 8,
    localparam int ptr_width_lp = $clog2(els_p),
    localparam int cnt_width_lp = $clog2(els_p + 1))
  (input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i);

  logic [width_p-1:0]      mem [els_p];
  logic [ptr_width_lp-1:0] wptr_r, rptr_r;
  logic [cnt_width_lp-1:0] count_r;
  logic                    enq, deq;

  assign ready_o = (count_r != cnt_width_lp'(els_p));
  assign v_o     = (count_r != '0);
  assign data_o  = mem[rptr_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr_r] <= data_i;
  end

  // els_p is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= wptr_r + ptr_width_lp'(1);
      if (deq) rptr_r <= rptr_r + ptr_width_lp'(1);
      if (enq && !deq)      count_r <= count_r + cnt_width_lp'(1);
      else if (deq && !enq) count_r <= count_r - cnt_width_lp'(1);
    end
  end

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// Merges late writebacks from mem, idiv and fdiv into one writeback port with a
// round-robin grant that locks while a presented packet waits for yumi.
module bp_be_late_wb_arbiter
  import bp_be_pkg::*;
  #(parameter int num_src_p        = 3,
    parameter int els_p            = 2,
    parameter int data_width_p     = 64,
    parameter int reg_addr_width_p = 5,
    parameter int fflags_width_p   = 5,
    localparam int src_width_lp    = $clog2(num_src_p))
  (input  logic                                   clk_i,
   input  logic                                   reset_n_i,
   input  logic [num_src_p-1:0]                   src_v_i,
   output logic [num_src_p-1:0]                   src_ready_o,
   input  logic [num_src_p-1:0]                   src_ird_w_v_i,
   input  logic [num_src_p-1:0]                   src_frd_w_v_i,
   input  logic [num_src_p*reg_addr_width_p-1:0]  src_rd_addr_i,
   input  logic [num_src_p*data_width_p-1:0]      src_data_i,
   input  logic [num_src_p*fflags_width_p-1:0]    src_fflags_i,
   output logic                                   late_wb_v_o,
   output logic                                   late_wb_ird_w_v_o,
   output logic                                   late_wb_frd_w_v_o,
   output logic [reg_addr_width_p-1:0]            late_wb_rd_addr_o,
   output logic [data_width_p-1:0]                late_wb_data_o,
   output logic [fflags_width_p-1:0]              late_wb_fflags_o,
   output logic [src_width_lp-1:0]                late_wb_src_o,
   input  logic                                   late_wb_yumi_i,
   output logic                                   idle_o);

  localparam int pkt_width_lp = 2 + reg_addr_width_p + data_width_p + fflags_width_p;

  logic [num_src_p-1:0]    cand;
  logic [pkt_width_lp-1:0] head [num_src_p];
  logic [pkt_width_lp-1:0] out_pkt;
  logic [src_width_lp-1:0] rr_ptr_r, lock_src_r, rr_sel, grant;
  logic                    lock_r, deq;

  assign deq = late_wb_v_o & late_wb_yumi_i;

  for (genvar g = 0; g < num_src_p; g++) begin : src
    logic                    keep;
    logic [pkt_width_lp-1:0] pkt_in;

    // packets that write neither RF complete the handshake but are not stored
    assign keep   = src_ird_w_v_i[g] | src_frd_w_v_i[g];
    assign pkt_in = {src_ird_w_v_i[g], src_frd_w_v_i[g],
                     src_rd_addr_i[g*reg_addr_width_p +: reg_addr_width_p],
                     src_data_i[g*data_width_p +: data_width_p],
                     src_fflags_i[g*fflags_width_p +: fflags_width_p]};

    bp_be_late_wb_fifo #(.els_p(els_p), .width_p(pkt_width_lp)) fifo
      (.clk_i    (clk_i),
       .reset_n_i(reset_n_i),
       .v_i      (src_v_i[g] & keep),
       .ready_o  (src_ready_o[g]),
       .data_i   (pkt_in),
       .v_o      (cand[g]),
       .data_o   (head[g]),
       .yumi_i   (deq && (grant == src_width_lp'(g))));

    assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(src_v_i[g] && src_ready_o[g] && src_ird_w_v_i[g] && src_frd_w_v_i[g]));
  end

  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    late_wb_yumi_i |-> late_wb_v_o);

  always_comb begin
    logic [src_width_lp:0]   sum;
    logic [src_width_lp-1:0] idx;
    logic                    found;
    rr_sel = rr_ptr_r;
    sum    = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < num_src_p; k++) begin
      sum = {1'b0, rr_ptr_r} + (src_width_lp+1)'(k);
      if (sum >= (src_width_lp+1)'(num_src_p)) sum = sum - (src_width_lp+1)'(num_src_p);
      idx = sum[src_width_lp-1:0];
      if (!found && cand[idx]) begin
        rr_sel = idx;
        found  = 1'b1;
      end
    end
  end

  assign grant       = lock_r ? lock_src_r : rr_sel;
  assign late_wb_v_o = |cand;
  assign idle_o      = ~|cand;
  assign out_pkt     = late_wb_v_o ? head[grant] : '0;
  assign late_wb_src_o = late_wb_v_o ? grant : '0;
  assign {late_wb_ird_w_v_o, late_wb_frd_w_v_o, late_wb_rd_addr_o,
          late_wb_data_o, late_wb_fflags_o} = out_pkt;

  // a stalled grant is frozen so the presented fields stay stable until yumi
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_r   <= '0;
      lock_src_r <= '0;
      lock_r     <= 1'b0;
    end else begin
      lock_r     <= late_wb_v_o & ~late_wb_yumi_i;
      lock_src_r <= grant;
      if (deq) rr_ptr_r <= (grant == src_width_lp'(num_src_p-1)) ? '0
                                                                  : grant + src_width_lp'(1);
    end
  end

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// Bench for the late writeback arbiter: directed vector table plus random
// traffic checked against a queue-based model of the source buffers.
module tb_bp_be_late_wb_arbiter;
  import bp_be_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   src_v, src_ready, ird, frd;
  logic [14:0]  rd_addr;
  logic [191:0] data;
  logic [14:0]  fflags;
  logic         wb_v, wb_ird, wb_frd, wb_yumi, idle;
  logic [4:0]   wb_rd;
  logic [63:0]  wb_data;
  logic [4:0]   wb_ff;
  logic [1:0]   wb_src;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bp_be_late_wb_arbiter dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .src_v_i(src_v), .src_ready_o(src_ready),
    .src_ird_w_v_i(ird), .src_frd_w_v_i(frd),
    .src_rd_addr_i(rd_addr), .src_data_i(data), .src_fflags_i(fflags),
    .late_wb_v_o(wb_v), .late_wb_ird_w_v_o(wb_ird), .late_wb_frd_w_v_o(wb_frd),
    .late_wb_rd_addr_o(wb_rd), .late_wb_data_o(wb_data), .late_wb_fflags_o(wb_ff),
    .late_wb_src_o(wb_src), .late_wb_yumi_i(wb_yumi), .idle_o(idle));

  // reference model: one queue per source, round-robin pointer and held grant
  bp_be_wb_pkt_s mq [3][$];
  int rr_m = 0;
  bit lock_m = 0;
  int lock_src_m = 0;

  function automatic bit m_valid();
    return (mq[0].size() + mq[1].size() + mq[2].size()) != 0;
  endfunction

  function automatic int m_grant();
    if (lock_m) return lock_src_m;
    for (int k = 0; k < 3; k++)
      if (mq[(rr_m + k) % 3].size() != 0) return (rr_m + k) % 3;
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) mq[i].delete();
    rr_m = 0; lock_m = 0; lock_src_m = 0;
  endtask

  task automatic m_update();
    bit rdy [3];
    int g;
    bp_be_wb_pkt_s p;
    for (int i = 0; i < 3; i++) rdy[i] = mq[i].size() < 2;
    if (m_valid()) begin
      g = m_grant();
      if (wb_yumi) begin
        void'(mq[g].pop_front());
        rr_m = (g + 1) % 3;
        lock_m = 0;
      end else begin
        lock_m = 1;
        lock_src_m = g;
      end
    end else lock_m = 0;
    for (int i = 0; i < 3; i++) begin
      if (src_v[i] && rdy[i] && (ird[i] || frd[i])) begin
        p.ird_w_v = ird[i];
        p.frd_w_v = frd[i];
        p.rd_addr = rd_addr[i*5 +: 5];
        p.data    = data[i*64 +: 64];
        p.fflags  = fflags[i*5 +: 5];
        mq[i].push_back(p);
      end
    end
  endtask

  task automatic check_model();
    logic [82:0] e, a;
    bp_be_wb_pkt_s p;
    logic [2:0] rdy;
    int g;
    p = '0;
    g = 0;
    if (m_valid()) begin
      g = m_grant();
      p = mq[g][0];
    end
    for (int i = 0; i < 3; i++) rdy[i] = mq[i].size() < 2;
    e = {m_valid(), 2'(g), p, rdy, !m_valid()};
    a = {wb_v, wb_src, wb_ird, wb_frd, wb_rd, wb_data, wb_ff, src_ready, idle};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t: got %h expected %h", $time, a, e);
    end
  endtask

  // drive at posedge+1, sample at posedge+5 (negedge), update model at posedge
  task automatic begin_cycle(input bit rst);
    rst_n = !rst;
    if (rst) m_reset();
    #4;
    check_model();
  endtask

  task automatic end_cycle(input bit rst);
    @(posedge clk);
    if (!rst) m_update();
    #1;
  endtask

  task automatic clear_inputs();
    src_v = '0; ird = '0; frd = '0; rd_addr = '0; data = '0; fflags = '0; wb_yumi = 1'b0;
  endtask

  typedef struct {
    bit       rst;
    bit       drop;
    bit [2:0] v;
    bit       y;
    bit       ev;
    int       es;
    bit [2:0] er;
    bit       ei;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(bit rst, bit drop, bit [2:0] v, bit y,
                              bit ev, int es, bit [2:0] er, bit ei);
    vec_t t;
    t.rst = rst; t.drop = drop; t.v = v; t.y = y;
    t.ev = ev; t.es = es; t.er = er; t.ei = ei;
    return t;
  endfunction

  task automatic drive_table_src(input vec_t t);
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      src_v[i] = t.v[i];
      ird[i]   = !t.drop && (i != int'(e_late_src_fdiv));
      frd[i]   = !t.drop && (i == int'(e_late_src_fdiv));
      rd_addr[i*5 +: 5] = 5'(4 + i);
      data[i*64 +: 64]  = 64'h0234 | (64'(i) << 12);
      fflags[i*5 +: 5]  = (i == 2) ? 5'h3 : 5'h0;
    end
    wb_yumi = t.y;
  endtask

  initial begin
    logic [74:0] te, ta;
    logic [4:0]  erd;
    logic [63:0] edat;

    rst_n = 1'b0;
    clear_inputs();

    // idiv single packet
    tbl.push_back(mk(1,0,3'b000,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,0,3'b010,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,0,3'b000,1, 1,1,3'b111,0));
    tbl.push_back(mk(0,0,3'b000,0, 0,0,3'b111,1));
    // two round-robin rounds
    tbl.push_back(mk(1,0,3'b000,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,0,3'b111,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,0,3'b000,1, 1,0,3'b111,0));
    tbl.push_back(mk(0,0,3'b000,1, 1,1,3'b111,0));
    tbl.push_back(mk(0,0,3'b000,1, 1,2,3'b111,0));
    tbl.push_back(mk(0,0,3'b111,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,0,3'b000,1, 1,0,3'b111,0));
    tbl.push_back(mk(0,0,3'b000,1, 1,1,3'b111,0));
    tbl.push_back(mk(0,0,3'b000,1, 1,2,3'b111,0));
    tbl.push_back(mk(0,0,3'b000,0, 0,0,3'b111,1));
    // stall with rr_ptr at fdiv: locked mem packet holds while fdiv arrives
    tbl.push_back(mk(1,0,3'b000,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,0,3'b010,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,0,3'b000,1, 1,1,3'b111,0));
    tbl.push_back(mk(0,0,3'b001,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,0,3'b000,0, 1,0,3'b111,0));
    tbl.push_back(mk(0,0,3'b100,0, 1,0,3'b111,0));
    tbl.push_back(mk(0,0,3'b000,0, 1,0,3'b111,0));
    tbl.push_back(mk(0,0,3'b000,0, 1,0,3'b111,0));
    tbl.push_back(mk(0,0,3'b000,1, 1,0,3'b111,0));
    tbl.push_back(mk(0,0,3'b000,1, 1,2,3'b111,0));
    tbl.push_back(mk(0,0,3'b000,0, 0,0,3'b111,1));
    // backpressure on mem, including dequeue while full
    tbl.push_back(mk(1,0,3'b000,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,0,3'b001,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,0,3'b001,0, 1,0,3'b111,0));
    tbl.push_back(mk(0,0,3'b001,0, 1,0,3'b110,0));
    tbl.push_back(mk(0,0,3'b001,1, 1,0,3'b110,0));
    tbl.push_back(mk(0,0,3'b000,0, 1,0,3'b111,0));
    tbl.push_back(mk(0,0,3'b000,1, 1,0,3'b111,0));
    tbl.push_back(mk(0,0,3'b000,0, 0,0,3'b111,1));
    // packet writing neither RF is dropped
    tbl.push_back(mk(1,0,3'b000,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,1,3'b010,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,0,3'b000,0, 0,0,3'b111,1));
    // reset while every buffer is full
    tbl.push_back(mk(1,0,3'b000,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,0,3'b111,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,0,3'b111,0, 1,0,3'b111,0));
    tbl.push_back(mk(1,0,3'b000,0, 0,0,3'b111,1));
    tbl.push_back(mk(0,0,3'b000,0, 0,0,3'b111,1));

    @(posedge clk);
    #1;
    foreach (tbl[n]) begin
      drive_table_src(tbl[n]);
      begin_cycle(tbl[n].rst);
      erd  = tbl[n].ev ? 5'(4 + tbl[n].es) : 5'd0;
      edat = tbl[n].ev ? (64'h0234 | (64'(tbl[n].es) << 12)) : 64'd0;
      te = {tbl[n].ev, 2'(tbl[n].es), erd, edat, tbl[n].er, tbl[n].ei};
      ta = {wb_v, wb_src, wb_rd, wb_data, src_ready, idle};
      n_checks++;
      if (ta !== te) begin
        n_fail++;
        $display("FAIL vec%0d: got %h expected %h", n, ta, te);
      end
      end_cycle(tbl[n].rst);
    end

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit do_rst;
      int kind;
      do_rst = ($urandom_range(0, 249) == 0);
      clear_inputs();
      if (!do_rst) begin
        for (int i = 0; i < 3; i++) begin
          src_v[i] = ($urandom_range(0, 1) == 1);
          kind = $urandom_range(0, 7);
          ird[i] = (kind >= 1 && kind <= 5);
          frd[i] = (kind >= 6);
          rd_addr[i*5 +: 5] = 5'($urandom);
          data[i*64 +: 64]  = {$urandom, $urandom};
          fflags[i*5 +: 5]  = 5'($urandom);
        end
        wb_yumi = m_valid() && ($urandom_range(0, 2) != 0);
      end
      begin_cycle(do_rst);
      end_cycle(do_rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
